// File: rtl/mips_cpu_multdiv_pkg.sv
// Shared types and constants for the iterative MIPS HI/LO multiply/divide unit.
// Holds operand width, op encoding, FSM state encoding and divide-by-zero quotient.
package mips_cpu_multdiv_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] DIV0_QUO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_cpu_multdiv_signfix.sv
// Combinational conditional negate: y_o = neg_i ? -a_i : a_i.
// Ports: a_i value, neg_i negate request, y_o result. Used for abs and result fix-up.
module mips_cpu_multdiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o
);

  assign y_o = neg_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/mips_cpu_multdiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers (MFHI/MFLO, MTHI/MTLO).
// Ports: clk, reset (async high), start/op, rs_content/rt_content, mthi/mtlo in;
// busy, done (1-cycle pulse), hi, lo out. Macro MULTDIV_ZERO_FAST_EN enables the
// zero-operand shortcut straight to the fix-up state.
module mips_cpu_multdiv #(
  parameter int WIDTH  = mips_cpu_multdiv_pkg::WIDTH,
  parameter int ITER_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_content,
  input  logic [WIDTH-1:0] rt_content,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mips_cpu_multdiv_pkg::*;

  localparam logic [ITER_W-1:0] LAST = ITER_W'(WIDTH - 1);

  state_e             state_q;
  op_e                op_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [ITER_W-1:0]  cnt_q;
  // Upper half: partial product / remainder; lower half: multiplier / quotient.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   rs_q;
  logic               sa_q;
  logic               sb_q;
  logic               dz_q;

  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               fast_zero;
  logic               rt_zero;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_r;
  logic [WIDTH+1:0]   div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic               unused_trial;

  mips_cpu_multdiv_signfix #(.W(WIDTH)) u_abs_rs (
    .a_i   (rs_content),
    .neg_i (op[0] & rs_content[WIDTH-1]),
    .y_o   (rs_mag)
  );

  mips_cpu_multdiv_signfix #(.W(WIDTH)) u_abs_rt (
    .a_i   (rt_content),
    .neg_i (op[0] & rt_content[WIDTH-1]),
    .y_o   (rt_mag)
  );

  mips_cpu_multdiv_signfix #(.W(2*WIDTH)) u_fix_prod (
    .a_i   (acc_q),
    .neg_i (op_q[0] & (sa_q ^ sb_q)),
    .y_o   (prod_fix)
  );

  mips_cpu_multdiv_signfix #(.W(WIDTH)) u_fix_quo (
    .a_i   (acc_q[WIDTH-1:0]),
    .neg_i (op_q[0] & (sa_q ^ sb_q)),
    .y_o   (quo_fix)
  );

  // Remainder follows the dividend's sign.
  mips_cpu_multdiv_signfix #(.W(WIDTH)) u_fix_rem (
    .a_i   (acc_q[2*WIDTH-1:WIDTH]),
    .neg_i (op_q[0] & sa_q),
    .y_o   (rem_fix)
  );

  assign rt_zero = (rt_content == '0);

`ifdef MULTDIV_ZERO_FAST_EN
  logic rs_zero;
  assign rs_zero   = (rs_content == '0);
  assign fast_zero = op[1] ? rt_zero : (rs_zero | rt_zero);
`else
  assign fast_zero = 1'b0;
`endif

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + {1'b0, (acc_q[0] ? b_q : '0)};
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_r     = acc_q[2*WIDTH-1:WIDTH-1];
    div_trial = {1'b0, div_r} - {2'b00, b_q};
    // Negative trial: restore shifted remainder, quotient bit 0.
    div_next  = div_trial[WIDTH+1]
              ? {div_r[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
              : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  assign unused_trial = div_trial[WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULTU;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      rs_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q   <= op_e'(op);
            rs_q   <= rs_content;
            sa_q   <= rs_content[WIDTH-1];
            sb_q   <= rt_content[WIDTH-1];
            dz_q   <= op[1] & rt_zero;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            b_q    <= op[1] ? rt_mag : rs_mag;
            if (fast_zero) begin
              acc_q   <= '0;
              state_q <= S_FIX;
            end else begin
              acc_q   <= {{WIDTH{1'b0}}, (op[1] ? rs_mag : rt_mag)};
              state_q <= op[1] ? S_DIV : S_MUL;
            end
          end else begin
            if (mthi) hi_q <= rs_content;
            if (mtlo) lo_q <= rs_content;
          end
        end
        S_MUL: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q + ITER_W'(1);
          if (cnt_q == LAST) state_q <= S_FIX;
        end
        S_DIV: begin
          acc_q <= div_next;
          cnt_q <= cnt_q + ITER_W'(1);
          if (cnt_q == LAST) state_q <= S_FIX;
        end
        S_FIX: begin
          if (!op_q[1]) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end else if (dz_q) begin
            hi_q <= rs_q;
            lo_q <= DIV0_QUO;
          end else begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_multdiv.sv
// Self-checking bench for mips_cpu_multdiv: directed cases plus random ops
// compared against an arithmetic HI/LO reference model.
module tb_mips_cpu_multdiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int npass = 0;
  int ntot  = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  always #5 clk = ~clk;

  mips_cpu_multdiv dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .rs_content (rs),
    .rt_content (rt),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] h,
                                output logic [31:0] l);
    logic [63:0] p;
    int sa, sb;
    p = '0;
    h = '0;
    l = '0;
    sa = $signed(a);
    sb = $signed(b);
    case (o)
      2'b00: begin
        p = {32'b0, a} * {32'b0, b};
        h = p[63:32];
        l = p[31:0];
      end
      2'b01: begin
        p = longint'(sa) * longint'(sb);
        h = p[63:32];
        l = p[31:0];
      end
      2'b10: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin l = a / b; h = a % b; end
      end
      default: begin
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          h = 0;
          l = 32'h8000_0000;
        end else begin
          l = sa / sb;
          h = sa % sb;
        end
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
    int lat;
    lat = 33;
`ifdef MULTDIV_ZERO_FAST_EN
    if ((o[1] && b == 0) || (!o[1] && (a == 0 || b == 0))) lat = 1;
`endif
    return lat;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] eh, el;
    int n;
    int lat;
    logic held;
    model(o, a, b, eh, el);
    lat = exp_lat(o, a, b);
    op = o;
    rs = a;
    rt = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    n = 0;
    held = 1'b1;
    while (!done && n < 40) begin
      if (hi !== mhi || lo !== mlo) held = 1'b0;
      @(posedge clk);
      #1 n++;
    end
    chk("latency", n, lat);
    chk("hilo_held", {31'b0, held}, 32'd1);
    chk("busy_at_done", {31'b0, busy}, 32'd0);
    chk("hi", hi, eh);
    chk("lo", lo, el);
    mhi = eh;
    mlo = el;
    @(posedge clk);
    #1 chk("done_pulse_end", {31'b0, done}, 32'd0);
  endtask

  initial begin
    int pulses;
    int seen;
    logic [1:0] ro;
    logic [31:0] ra, rb;

    reset = 1'b1;
    start = 1'b0;
    op = 2'b00;
    rs = '0;
    rt = '0;
    mthi = 1'b0;
    mtlo = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b10, 32'h64, 32'd0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b11, 32'hFFFF_FFF0, 32'd0);
    run_op(2'b00, 32'd0, 32'd9);

    // Start and MTHI while busy must not disturb DIVU 100/7.
    op = 2'b10;
    rs = 32'd100;
    rt = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0;
    seen = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c == 10) begin
        start = 1'b1;
        op = 2'b00;
        mthi = 1'b1;
        rs = 32'hDEAD;
      end
      @(posedge clk);
      #1;
      if (c == 10) begin
        start = 1'b0;
        mthi = 1'b0;
      end
      if (done) begin
        pulses++;
        if (seen < 0) seen = c;
      end
    end
    chk("busy_ign_when", seen, 33);
    chk("busy_ign_pulses", pulses, 1);
    chk("busy_ign_lo", lo, 32'd14);
    chk("busy_ign_hi", hi, 32'd2);
    mhi = 32'd2;
    mlo = 32'd14;

    // Both moves in one idle cycle.
    rs = 32'hA5A5_0F0F;
    mthi = 1'b1;
    mtlo = 1'b1;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mt_both_hi", hi, 32'hA5A5_0F0F);
    chk("mt_both_lo", lo, 32'hA5A5_0F0F);
    mhi = 32'hA5A5_0F0F;
    mlo = 32'hA5A5_0F0F;

    // Start wins over a simultaneous move.
    op = 2'b00;
    rs = 32'd2;
    rt = 32'd3;
    start = 1'b1;
    mthi = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mthi = 1'b0;
    chk("start_wins_hi", hi, mhi);
    seen = 0;
    while (!done && seen < 40) begin
      @(posedge clk);
      #1 seen++;
    end
    chk("start_wins_lat", seen, 33);
    chk("start_wins_res_hi", hi, 32'd0);
    chk("start_wins_res_lo", lo, 32'd6);
    mhi = 32'd0;
    mlo = 32'd6;

    // Asynchronous reset in the middle of a MULT.
    op = 2'b01;
    rs = 32'd7;
    rt = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    mhi = '0;
    mlo = '0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    chk("midrst_discard", pulses, 0);
    chk("midrst_lo_after", lo, 32'd0);
    rs = 32'h1234;
    mtlo = 1'b1;
    @(posedge clk);
    #1 mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'h1234);
    chk("mtlo_hi", hi, 32'd0);
    mlo = 32'h1234;

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      if ($urandom_range(0, 7) == 0) ra = 32'd0;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 20);
      run_op(ro, ra, rb);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
